// File: rtl/hazard_control_unit.sv
// Hazard control for a 5-stage pipeline with 20-bit instructions: stall, flush and operand-forward selects.
// Optional feature macro HAZARD_FORWARDING_EN enables EX/MEM and MEM/WB forwarding with load-use stalls only.
module hazard_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [19:0]      instr_id,
    input  logic             instr_valid,
    input  logic             branch_taken_ex,
    output logic             stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b1011;
    localparam logic [3:0] OP_STORE  = 4'b1100;
    localparam logic [3:0] OP_BRANCH = 4'b1101;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

    function automatic logic is_writer(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

    ctrl_state_e      state_r, state_next_s;
    logic             id_valid_s, id_writer_s;
    logic             use_a_s, use_b_s;
    logic [3:0]       src_a_s, src_b_s;
    logic             hit_ex_a_s, hit_ex_b_s, hit_mem_a_s, hit_mem_b_s;
    logic             hazard_s, stall_s, flush_s, advance_s;
    logic             ex_valid_r, mem_valid_r, wb_valid_r;
    logic [3:0]       ex_rd_r, mem_rd_r, wb_rd_r;
    logic [CNT_W-1:0] cnt_r;
    logic             instr_unused_s;

    assign instr_unused_s = ^instr_id[3:0];

    // Decode the ID instruction into its source operands; FLUSH or invalid input acts as a NOP.
    always_comb begin
        id_valid_s = instr_valid && (state_r != ST_FLUSH);
        src_a_s    = instr_id[11:8];
        src_b_s    = instr_id[7:4];
        use_a_s    = 1'b0;
        use_b_s    = 1'b0;
        case (instr_id[19:16])
            OP_NOP: begin
                use_a_s = 1'b0;
                use_b_s = 1'b0;
            end
            OP_LOAD: begin
                use_a_s = 1'b1;
            end
            OP_STORE: begin
                // store reads its data in [15:12] and base in [11:8], mapped to A and B in that order
                src_a_s = instr_id[15:12];
                src_b_s = instr_id[11:8];
                use_a_s = 1'b1;
                use_b_s = 1'b1;
            end
            default: begin
                use_a_s = 1'b1;
                use_b_s = 1'b1;
            end
        endcase
        if (!id_valid_s) begin
            use_a_s = 1'b0;
            use_b_s = 1'b0;
        end else begin
            use_a_s = use_a_s;
            use_b_s = use_b_s;
        end
        id_writer_s = id_valid_s && is_writer(instr_id[19:16]);
    end

    // Compare ID sources against in-flight writers.
    always_comb begin
        hit_ex_a_s  = use_a_s && ex_valid_r  && (ex_rd_r  == src_a_s);
        hit_ex_b_s  = use_b_s && ex_valid_r  && (ex_rd_r  == src_b_s);
        hit_mem_a_s = use_a_s && mem_valid_r && (mem_rd_r == src_a_s);
        hit_mem_b_s = use_b_s && mem_valid_r && (mem_rd_r == src_b_s);
    end

`ifdef HAZARD_FORWARDING_EN
    logic       ex_load_r;
    logic [1:0] fwd_a_r, fwd_b_r;

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return 2'b01;
        end else if (mem_hit) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    // Only a load in EX cannot be forwarded in time.
    always_comb begin
        hazard_s = ex_valid_r && ex_load_r && (hit_ex_a_s || hit_ex_b_s);
    end

    // Forward selects travel with the instruction into EX; bubbles read the register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_load_r <= 1'b0;
            fwd_a_r   <= 2'b00;
            fwd_b_r   <= 2'b00;
        end else if (advance_s) begin
            ex_load_r <= id_writer_s && (instr_id[19:16] == OP_LOAD);
            fwd_a_r   <= fwd_sel(hit_ex_a_s, hit_mem_a_s);
            fwd_b_r   <= fwd_sel(hit_ex_b_s, hit_mem_b_s);
        end else begin
            ex_load_r <= 1'b0;
            fwd_a_r   <= 2'b00;
            fwd_b_r   <= 2'b00;
        end
    end

    assign fwd_a = fwd_a_r;
    assign fwd_b = fwd_b_r;
`else
    logic hit_wb_a_s, hit_wb_b_s;

    // Without forwarding every in-flight writer blocks a reader until it has left WB.
    always_comb begin
        hit_wb_a_s = use_a_s && wb_valid_r && (wb_rd_r == src_a_s);
        hit_wb_b_s = use_b_s && wb_valid_r && (wb_rd_r == src_b_s);
        hazard_s   = hit_ex_a_s || hit_ex_b_s || hit_mem_a_s || hit_mem_b_s
                     || hit_wb_a_s || hit_wb_b_s;
    end

    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    // A taken branch overrides any hazard; all control is quiet while reset is held.
    always_comb begin
        flush_s   = reset && branch_taken_ex;
        stall_s   = reset && hazard_s && !branch_taken_ex;
        advance_s = !stall_s && !flush_s;
    end

    // Destination tracking pipe: ID -> EX -> MEM -> WB.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid_r  <= 1'b0;
            mem_valid_r <= 1'b0;
            wb_valid_r  <= 1'b0;
            ex_rd_r     <= 4'd0;
            mem_rd_r    <= 4'd0;
            wb_rd_r     <= 4'd0;
        end else begin
            ex_valid_r  <= advance_s && id_writer_s;
            ex_rd_r     <= instr_id[15:12];
            mem_valid_r <= ex_valid_r;
            mem_rd_r    <= ex_rd_r;
            wb_valid_r  <= mem_valid_r;
            wb_rd_r     <= mem_rd_r;
        end
    end

    // Control FSM next-state.
    always_comb begin
        state_next_s = state_r;
        if (branch_taken_ex) begin
            state_next_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_RUN:   state_next_s = stall_s ? ST_STALL : ST_RUN;
                ST_STALL: state_next_s = stall_s ? ST_STALL : ST_RUN;
                ST_FLUSH: state_next_s = ST_RUN;
                default:  state_next_s = ST_RUN;
            endcase
        end
    end

    // FSM state register and saturating stall counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign stall       = stall_s;
    assign flush_ifid  = flush_s;
    assign flush_idex  = flush_s;
    assign ctrl_state  = state_r;
    assign stall_count = cnt_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed vectors push expected outputs, a negedge monitor compares.
module tb_hazard_control_unit;

    logic        clock;
    logic        reset;
    logic [19:0] instr_id;
    logic        instr_valid;
    logic        branch_taken_ex;
    logic        stall, flush_ifid, flush_idex;
    logic [1:0]  fwd_a, fwd_b, ctrl_state;
    logic [15:0] stall_count;

    hazard_control_unit dut (
        .clock           (clock),
        .reset           (reset),
        .instr_id        (instr_id),
        .instr_valid     (instr_valid),
        .branch_taken_ex (branch_taken_ex),
        .stall           (stall),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .ctrl_state      (ctrl_state),
        .stall_count     (stall_count)
    );

    typedef struct packed {
        int          idx;
        logic [8:0]  flags;   // {stall, flush_ifid, flush_idex, fwd_a, fwd_b, ctrl_state}
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_n    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: outputs are sampled mid-cycle, after the inputs of that cycle settle.
    always @(negedge clock) begin
        exp_t       e;
        logic [8:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {stall, flush_ifid, flush_idex, fwd_a, fwd_b, ctrl_state};
            checks++;
            if ((act !== e.flags) || (stall_count !== e.cnt)) begin
                failures++;
                $display("FAIL vec%0d: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                         e.idx, act, stall_count, e.flags, e.cnt);
            end
        end
    end

    task automatic cyc(input logic rs, input logic [19:0] ins, input logic v, input logic br,
                       input logic [8:0] ef, input logic [15:0] ec);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = rs;
        instr_id        = ins;
        instr_valid     = v;
        branch_taken_ex = br;
        e.idx   = vec_n;
        e.flags = ef;
        e.cnt   = ec;
        exp_q.push_back(e);
        vec_n++;
    endtask

    initial begin
        reset           = 1'b0;
        instr_id        = 20'h00000;
        instr_valid     = 1'b0;
        branch_taken_ex = 1'b0;
        // flags: stall_fi_fe_fa_fb_st
        cyc(1'b0, 20'h00000, 1'b0, 1'b1, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b0, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
`ifdef HAZARD_FORWARDING_EN
        cyc(1'b1, 20'h13120, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_01_00_00, 16'd0);
        cyc(1'b1, 20'hB6100, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b0_0_0_00_00_01, 16'd1);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_10_10_00, 16'd1);
        cyc(1'b1, 20'h13120, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'h13120, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_01_00_00, 16'd1);
        cyc(1'b1, 20'h13120, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'hC3100, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_01_00_00, 16'd1);
        cyc(1'b1, 20'hB6100, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'h17660, 1'b1, 1'b1, 9'b0_1_1_00_00_00, 16'd1);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b0_0_0_00_00_10, 16'd1);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'hB6100, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd1);
        cyc(1'b0, 20'h17660, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
`else
        // back-to-back ALU dependency stalls three cycles
        cyc(1'b1, 20'h13120, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b1_0_0_00_00_01, 16'd1);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b1_0_0_00_00_01, 16'd2);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b0_0_0_00_00_01, 16'd3);
        cyc(1'b1, 20'h14400, 1'b0, 1'b0, 9'b0_0_0_00_00_00, 16'd3);
        // branch overrides a hazard from RUN, FLUSH hides ID, then RUN
        cyc(1'b1, 20'h15400, 1'b1, 1'b1, 9'b0_1_1_00_00_00, 16'd3);
        cyc(1'b1, 20'h15400, 1'b1, 1'b0, 9'b0_0_0_00_00_10, 16'd3);
        cyc(1'b1, 20'h15400, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd3);
        // branch arriving while already in STALL
        cyc(1'b1, 20'h16500, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd3);
        cyc(1'b1, 20'h16500, 1'b1, 1'b1, 9'b0_1_1_00_00_01, 16'd4);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_10, 16'd4);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_00, 16'd4);
        // reset mid-stall clears everything at once; SUB afterwards does not stall
        cyc(1'b1, 20'h13120, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd4);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd4);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b1_0_0_00_00_01, 16'd5);
        cyc(1'b0, 20'h24350, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h24350, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        // store is not a writer; branch reads rs1 and hits WB
        cyc(1'b1, 20'hC3100, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h17330, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'hD0400, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd0);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_01, 16'd1);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        // load ignores rs2 field; store data field hits MEM then WB
        cyc(1'b1, 20'h13120, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'hB6130, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'hC3100, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd1);
        cyc(1'b1, 20'hC3100, 1'b1, 1'b0, 9'b1_0_0_00_00_01, 16'd2);
        cyc(1'b1, 20'hC3100, 1'b1, 1'b0, 9'b0_0_0_00_00_01, 16'd3);
        // load-use without forwarding also waits three cycles
        cyc(1'b1, 20'hB6100, 1'b1, 1'b0, 9'b0_0_0_00_00_00, 16'd3);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b1_0_0_00_00_00, 16'd3);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b1_0_0_00_00_01, 16'd4);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b1_0_0_00_00_01, 16'd5);
        cyc(1'b1, 20'h17660, 1'b1, 1'b0, 9'b0_0_0_00_00_01, 16'd6);
        cyc(1'b1, 20'h00000, 1'b0, 1'b0, 9'b0_0_0_00_00_00, 16'd6);
`endif
        repeat (4) @(negedge clock);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
